cache_mem_ctrl: RTL and testbench
=================================

CACHE_MEM_CTRL -- requirements
Module: cache_mem_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to the ready pulse; legal range 1..255.
REQ-002 SHALL have parameter MEM_LINES, default 1024: number of 128-bit lines in the backing store; power of two.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port mem_req  input  mem_req_type  request from the cache: addr[31:0], data[127:0], rw (1 = write), valid.
REQ-006 SHALL have port mem_data  output  mem_data_type  response to the cache: data[127:0], ready.
REQ-007 SHALL have port stat_reads  output  32  count of completed reads.
REQ-008 SHALL have port stat_writes  output  32  count of completed writes.

Function
REQ-009 SHALL implement the FSM states IDLE, BUSY and RESPOND.
REQ-010 IDLE: with mem_req.valid=1 at a clock edge, SHALL latch addr, data and rw, load the counter with LATENCY-1, and go to BUSY; with valid=0, SHALL stay in IDLE.
REQ-011 BUSY: SHALL decrement the counter each cycle and ignore mem_req entirely; on the edge where the counter equals 0, SHALL go to RESPOND.
REQ-012 On the BUSY->RESPOND edge, a read SHALL register mem[line] into mem_data.data.
REQ-013 On the BUSY->RESPOND edge, a write SHALL store the latched data to mem[line] and echo it on mem_data.data.
REQ-014 RESPOND: mem_data.ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-015 The earliest next acceptance SHALL be the edge after the RESPOND cycle.
REQ-016 Ready SHALL rise exactly LATENCY+1 cycles after the accepting edge, for reads and writes alike; latency SHALL NOT depend on rw, address or data (no timing channel).
REQ-017 line SHALL be addr[$clog2(MEM_LINES)+3:4]; addr[3:0] and the upper addr bits SHALL be ignored, so out-of-range addresses alias.
REQ-018 mem_data.data SHALL hold its value outside RESPOND until the next response.
REQ-019 A write followed by a read of the same line SHALL return the written data (no stale read).
REQ-020 mem_req.valid dropping during BUSY SHALL NOT abort the transaction; it SHALL complete normally.
REQ-021 The backing store SHALL be zero at time zero and SHALL NOT be cleared by reset.

Reset
REQ-022 With rst=0 at a clock edge: state SHALL become IDLE, mem_data.ready 0, mem_data.data 0, counter 0, and stat_reads/stat_writes 0.
REQ-023 Reset during BUSY or RESPOND SHALL discard the pending transaction; a pending write SHALL NOT be committed if reset is asserted on the commit edge.
REQ-024 The first request SHALL be accepted no earlier than the first edge with rst=1.

Configuration
REQ-025 Macro CACHE_MEM_STATS_EN defined: stat_reads/stat_writes SHALL increment by 1 on each BUSY->RESPOND edge for a read/write respectively, wrapping at 2^32.
REQ-026 Macro CACHE_MEM_STATS_EN undefined: the stat ports SHALL still exist, tied to 0, and no counter logic SHALL be instantiated.

Structure
REQ-027 mem_req_type, mem_data_type and constant MEM_LATENCY_DEF (=4) SHALL reside in cache_pkg.
REQ-028 Line-index width SHALL be derived locally from MEM_LINES.
REQ-029 Storage SHALL be a sub-module cache_mem_array: single port, synchronous write, registered read, MEM_LINES x 128.
REQ-030 cache_mem_ctrl SHALL connect to cache_fsm mem_req/mem_data with no glue logic.

Verification
REQ-031 Reset, then read line 0x10 (addr 0x100): SHALL see ready exactly LATENCY+1 cycles after acceptance, data 0, ready high for 1 cycle.
REQ-032 Write addr 0x200 with data 0xDEADBEEF_0123_4567_89AB_CDEF_CAFEF00D, then read addr 0x20C: SHALL return identical data at identical latency.
REQ-033 Write then immediate read (valid held high through the ready cycle): SHALL accept the read on the edge after RESPOND; no request dropped or duplicated.
REQ-034 Assert reset in the BUSY cycle of a write to 0x300, then read 0x300: SHALL return 0; ready SHALL stay 0 during reset.
REQ-035 Address aliasing, MEM_LINES=1024: write 0x0000_4010, read 0x0000_0010: SHALL return the written data.
REQ-036 With CACHE_MEM_STATS_EN defined: 3 reads + 2 writes -> stat_reads=3, stat_writes=2. Without the macro: both SHALL read 0.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_pkg: shared request/response types and state encoding        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cache_pkg;

    localparam int MEM_LATENCY_DEF = 4;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_mem_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_mem_ctrl_if: cache <-> memory controller request/response    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface cache_mem_ctrl_if;
    import cache_pkg::*;

    mem_req_type  mem_req;
    mem_data_type mem_data;

    modport master (output mem_req, input  mem_data);
    modport slave  (input  mem_req, output mem_data);

endinterface
`default_nettype wire

// File: rtl/cache_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_fsm: fixed-latency IDLE/BUSY/RESPOND sequencer; optional     |
// | stat counters under CACHE_MEM_STATS_EN. Rev 1.0                    |
// +--------------------------------------------------------------------+
module cache_fsm
    import cache_pkg::*;
#(
    parameter  int LATENCY   = MEM_LATENCY_DEF,
    parameter  int MEM_LINES = 1024,
    localparam int c_LINE_W  = $clog2(MEM_LINES)
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire mem_req_type         mem_req,
    output mem_data_type             mem_data,
    output logic [31:0]              stat_reads,
    output logic [31:0]              stat_writes,
    output logic                     o_mem_en,
    output logic                     o_mem_we,
    output logic [c_LINE_W-1:0]      o_mem_addr,
    output logic [127:0]             o_mem_wdata,
    input  wire logic [127:0]        i_mem_rdata
);

    localparam logic [7:0] c_LOAD = 8'(LATENCY - 1);

    fsm_state_t          r_state;
    logic [7:0]          r_cnt;
    logic                r_ready;
    logic                r_rw;
    logic [c_LINE_W-1:0] r_line;
    logic [127:0]        r_wdata;
    logic                w_fire;
    logic                w_unused_addr;

    assign w_unused_addr = ^mem_req.addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_rw    <= 1'b0;
            r_line  <= '0;
            r_wdata <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mem_req.valid) begin
                        r_line  <= mem_req.addr[c_LINE_W+3:4];
                        r_wdata <= mem_req.data;
                        r_rw    <= mem_req.rw;
                        r_cnt   <= c_LOAD;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= RESPOND;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                RESPOND: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory access happens on the BUSY->RESPOND edge; reset on that edge blocks the commit.
    assign w_fire      = (r_state == BUSY) && (r_cnt == 8'd0) && rst;
    assign o_mem_en    = w_fire;
    assign o_mem_we    = w_fire && r_rw;
    assign o_mem_addr  = r_line;
    assign o_mem_wdata = r_wdata;
    assign mem_data    = '{data: i_mem_rdata, ready: r_ready};

`ifdef CACHE_MEM_STATS_EN
    logic [31:0] r_reads;
    logic [31:0] r_writes;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_reads  <= '0;
            r_writes <= '0;
        end else if (w_fire) begin
            if (r_rw) r_writes <= r_writes + 32'd1;
            else      r_reads  <= r_reads + 32'd1;
        end
    end

    assign stat_reads  = r_reads;
    assign stat_writes = r_writes;
`else
    assign stat_reads  = '0;
    assign stat_writes = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/cache_mem_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_mem_array: single-port MEM_LINES x 128 store, registered read |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cache_mem_array #(
    parameter  int MEM_LINES = 1024,
    localparam int c_LINE_W  = $clog2(MEM_LINES)
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_en,
    input  wire logic                i_we,
    input  wire logic [c_LINE_W-1:0] i_addr,
    input  wire logic [127:0]        i_wdata,
    output logic      [127:0]        o_rdata
);

    // Contents are deliberately untouched by reset; only the read register clears.
    logic [127:0] r_mem [MEM_LINES];
    logic [127:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_en) begin
            r_rdata <= i_we ? i_wdata : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cache_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_mem_ctrl: fixed-latency backing-store controller (top).      |
// | Optional macro CACHE_MEM_STATS_EN enables read/write counters.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cache_mem_ctrl
    import cache_pkg::*;
#(
    parameter  int LATENCY   = MEM_LATENCY_DEF,
    parameter  int MEM_LINES = 1024,
    localparam int c_LINE_W  = $clog2(MEM_LINES)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    cache_mem_ctrl_if.slave  bus,
    output logic [31:0]      stat_reads,
    output logic [31:0]      stat_writes
);

    logic                w_mem_en;
    logic                w_mem_we;
    logic [c_LINE_W-1:0] w_mem_addr;
    logic [127:0]        w_mem_wdata;
    logic [127:0]        w_mem_rdata;

    cache_fsm #(
        .LATENCY   (LATENCY),
        .MEM_LINES (MEM_LINES)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (bus.mem_req),
        .mem_data    (bus.mem_data),
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .o_mem_en    (w_mem_en),
        .o_mem_we    (w_mem_we),
        .o_mem_addr  (w_mem_addr),
        .o_mem_wdata (w_mem_wdata),
        .i_mem_rdata (w_mem_rdata)
    );

    cache_mem_array #(
        .MEM_LINES (MEM_LINES)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cache_mem_ctrl: directed self-checking bench for cache_mem_ctrl |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_cache_mem_ctrl;
    import cache_pkg::*;

    localparam int LAT   = 4;
    localparam int LINES = 1024;

    localparam logic [127:0] c_D1 = 128'hDEADBEEF_0123_4567_89AB_CDEF_CAFEF00D;
    localparam logic [127:0] c_D2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] c_D3 = 128'hA5A5_A5A5_5A5A_5A5A_A5A5_A5A5_5A5A_5A5A;
    localparam logic [127:0] c_D4 = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
    localparam logic [127:0] c_D5 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;
    int          n_vec = 0;
    int          n_err = 0;

    cache_mem_ctrl_if bus();

    cache_mem_ctrl #(
        .LATENCY   (LAT),
        .MEM_LINES (LINES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [127:0] obs, input logic [127:0] exp, input string tag);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until ready is seen (bounded).
    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.mem_data.ready !== 1'b1 && lat < 300);
    endtask

    task automatic txn(input logic [31:0] a, input logic [127:0] d, input logic rw,
                       input logic [127:0] exp, input string tag);
        int lat;
        @(negedge clk);
        bus.mem_req = '{addr: a, data: d, rw: rw, valid: 1'b1};
        @(posedge clk);
        #1 bus.mem_req.valid = 1'b0;
        wait_ready(lat);
        chk(128'(lat), 128'(LAT + 1), {tag, " latency"});
        chk(bus.mem_data.data, exp, {tag, " data"});
        @(negedge clk);
        chk(128'(bus.mem_data.ready), 128'(0), {tag, " pulse"});
        chk(bus.mem_data.data, exp, {tag, " hold"});
    endtask

    initial begin
        int lat;
        int hits;

        // Reset with a request pending: nothing may be accepted or reported.
        bus.mem_req = '{addr: 32'h100, data: '0, rw: 1'b0, valid: 1'b1};
        repeat (3) @(negedge clk);
        chk(128'(bus.mem_data.ready), 128'(0), "reset ready");
        chk(bus.mem_data.data, 128'(0), "reset data");
        chk(128'(stat_reads), 128'(0), "reset stat_reads");
        chk(128'(stat_writes), 128'(0), "reset stat_writes");
        bus.mem_req.valid = 1'b0;
        rst = 1'b1;

        txn(32'h0000_0100, '0, 1'b0, 128'(0), "read 0x100 zero");
        txn(32'h0000_0200, c_D1, 1'b1, c_D1, "write 0x200");
        txn(32'h0000_020C, '0, 1'b0, c_D1, "read 0x20C");

        // Valid held high through the ready cycle, then a read queued behind the write.
        @(negedge clk);
        bus.mem_req = '{addr: 32'h400, data: c_D2, rw: 1'b1, valid: 1'b1};
        @(posedge clk);
        wait_ready(lat);
        chk(128'(lat), 128'(LAT + 1), "b2b write latency");
        chk(bus.mem_data.data, c_D2, "b2b write echo");
        bus.mem_req = '{addr: 32'h400, data: '0, rw: 1'b0, valid: 1'b1};
        @(posedge clk);
        @(posedge clk);
        #1 bus.mem_req.valid = 1'b0;
        wait_ready(lat);
        chk(128'(lat), 128'(LAT + 1), "b2b read latency");
        chk(bus.mem_data.data, c_D2, "b2b read data");
        hits = 0;
        repeat (2 * LAT + 4) begin
            @(negedge clk);
            if (bus.mem_data.ready === 1'b1) hits++;
        end
        chk(128'(hits), 128'(0), "b2b no duplicate");

        // Reset lands on the commit edge of a write to 0x300.
        @(negedge clk);
        bus.mem_req = '{addr: 32'h300, data: c_D3, rw: 1'b1, valid: 1'b1};
        @(posedge clk);
        #1 bus.mem_req.valid = 1'b0;
        repeat (LAT) @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk(128'(bus.mem_data.ready), 128'(0), "reset-in-busy ready");
        end
        chk(bus.mem_data.data, 128'(0), "reset-in-busy data");
        chk(128'(stat_writes), 128'(0), "reset-in-busy stat_writes");
        rst = 1'b1;
        txn(32'h0000_0300, '0, 1'b0, 128'(0), "read 0x300 uncommitted");

        txn(32'h0000_4010, c_D4, 1'b1, c_D4, "write alias 0x4010");
        txn(32'h0000_0010, '0, 1'b0, c_D4, "read alias 0x0010");

        txn(32'h0000_0500, c_D5, 1'b1, c_D5, "write 0x500");
        txn(32'h0000_0500, '0, 1'b0, c_D5, "read 0x500");

`ifdef CACHE_MEM_STATS_EN
        chk(128'(stat_reads), 128'(3), "stat_reads");
        chk(128'(stat_writes), 128'(2), "stat_writes");
`else
        chk(128'(stat_reads), 128'(0), "stat_reads");
        chk(128'(stat_writes), 128'(0), "stat_writes");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
